// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg : JK command encodings, excitation function, parameter limits
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  localparam int WIDTH_MIN   = 1;
  localparam int WIDTH_MAX   = 16;
  localparam int MODULUS_MIN = 2;

  // Bits that keep their value get HOLD, so TOGGLE is never issued.
  function automatic logic [1:0] jk_excite(input logic q, input logic n);
    return {~q & n, q & ~n};
  endfunction

  function automatic bit params_legal(input int width, input int modulus);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (modulus >= MODULUS_MIN) && (modulus <= (1 << width));
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_ff_cell.sv
// ---------------------------------------------------------------------------
// jk_ff_cell : single JK flip-flop with active-low async reset, Q and Q-bar
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_ff_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case (jk_cmd_e'({j, k}))
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

  assign q_n = ~q;

endmodule

`default_nettype wire

// File: rtl/jk_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_updown_counter : modulo-MODULUS up/down counter built from JK cells.
// Optional parallel load with range check under JK_UPDOWN_COUNTER_LOAD_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             i_CLOCK_POS,
  input  logic             i_RESET_NEG,
  input  logic             i_ENABLE,
  input  logic             i_UP_DOWN,
  input  logic             i_LOAD,
  input  logic [WIDTH-1:0] i_LOAD_VALUE,
  output logic [WIDTH-1:0] o_COUNT,
  output logic [WIDTH-1:0] o_COUNT_NEG,
  output logic             o_TERMINAL,
  output logic             o_WRAP,
  output logic             o_LOAD_ERROR
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("jk_updown_counter: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] next_count;
  logic             at_top;
  logic             at_bottom;
  logic             load_active;
  logic             load_ok;
  logic             terminal;
  logic             wrap;

`ifdef JK_UPDOWN_COUNTER_LOAD_EN
  localparam logic [31:0] MODULUS_U = 32'(MODULUS);

  logic load_error;

  assign load_active = i_LOAD;
  assign load_ok     = 32'(i_LOAD_VALUE) < MODULUS_U;

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      load_error <= 1'b0;
    end else begin
      load_error <= load_active & ~load_ok;
    end
  end

  assign o_LOAD_ERROR = load_error;
`else
  logic unused_load;

  assign unused_load  = ^{i_LOAD, i_LOAD_VALUE};
  assign load_active  = 1'b0;
  assign load_ok      = 1'b0;
  assign o_LOAD_ERROR = 1'b0;
`endif

  assign at_top    = (count == MAX_COUNT);
  assign at_bottom = (count == '0);

  // Boundary is tested before stepping, so count+1 never exceeds MAX_COUNT.
  always_comb begin
    next_count = count;
    if (load_active) begin
      if (load_ok) begin
        next_count = i_LOAD_VALUE;
      end
    end else if (i_ENABLE) begin
      if (i_UP_DOWN) begin
        next_count = at_top ? '0 : count + WIDTH'(1);
      end else begin
        next_count = at_bottom ? MAX_COUNT : count - WIDTH'(1);
      end
    end
  end

  assign terminal = i_ENABLE & ~load_active & (i_UP_DOWN ? at_top : at_bottom);

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      wrap <= 1'b0;
    end else begin
      wrap <= terminal;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    logic [1:0] jk;

    assign jk = jk_excite(count[i], next_count[i]);

    jk_ff_cell u_cell (
      .clk  (i_CLOCK_POS),
      .rst_n(i_RESET_NEG),
      .j    (jk[1]),
      .k    (jk[0]),
      .q    (count[i]),
      .q_n  (count_n[i])
    );
  end

  assign o_COUNT     = count;
  assign o_COUNT_NEG = count_n;
  assign o_TERMINAL  = terminal;
  assign o_WRAP      = wrap;

endmodule

`default_nettype wire
